// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment glyph constants and scanner controller state encoding
package seg7_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_COMMIT} state_t;
    localparam logic [6:0] GLYPH_DASH  = 7'b1111110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [15:0][6:0] GLYPH_HEX = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0001100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };
endpackage

// File: rtl/mod_seg_glyph.sv
// mod_seg_glyph: nibble/blank/dash/dp to active-low {A..G,Dp} cathode pattern
module mod_seg_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       dash,
    input  logic       dp,
    output logic [7:0] cathode
);
    always_comb cathode = {dash ? GLYPH_DASH : blank ? GLYPH_BLANK : GLYPH_HEX[nibble], ~dp};
endmodule

// File: rtl/mod_seven_segment_scanner.sv
// mod_seven_segment_scanner: hex/decimal value capture, shift-add-3 conversion and multiplexed digit scan
module mod_seven_segment_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_value,
    input  logic                  in_mode,
    input  logic [NUM_DIGITS-1:0] in_dp,
    input  logic                  in_blank_lz,
    output logic [NUM_DIGITS-1:0] rg_anode,
    output logic [7:0]            rg_cathode,
    output logic                  overflow
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic [BIN_W-1:0]      sh_q, sh_d;
    logic [DW-1:0]         bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic [NUM_DIGITS-1:0] pdp_q, pdp_d;
    logic                  blz_q, blz_d;
    logic [DW-1:0]         nib_q, nib_d;
    logic [NUM_DIGITS-1:0] bdp_q, bdp_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic                  dash_q, dash_d;
    logic                  overflow_q, overflow_d;
    logic [RW-1:0]         rcnt_q, rcnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         cur_q, cur_d;
    logic                  on_q, on_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [7:0]            cathode_q, cathode_d;
    logic [DW-1:0]         adj, commit_nib;
    logic [NUM_DIGITS-1:0] commit_blank;
    logic                  seen, tc;
    logic [7:0]            glyph;

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++)
            adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        commit_nib = mode_q ? bcd_q : DW'(sh_q);
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen = seen | (commit_nib[4*i +: 4] != 4'd0) | (i == 0);
            commit_blank[i] = blz_q & ~seen;
        end
    end

    // bits shifted out of the top BCD digit mean the value needs more digits than the display has
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        pdp_d      = pdp_q;
        blz_d      = blz_q;
        nib_d      = nib_q;
        bdp_d      = bdp_q;
        blank_d    = blank_q;
        dash_d     = dash_q;
        overflow_d = overflow_q;
        if (state_q == ST_IDLE && in_valid && in_ready_q) begin
            sh_d    = in_value;
            mode_d  = in_mode;
            pdp_d   = in_dp;
            blz_d   = in_blank_lz;
            bcd_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            state_d = in_mode ? ST_CONVERT : ST_COMMIT;
        end else if (state_q == ST_CONVERT) begin
            bcd_d   = {adj[DW-2:0], sh_q[BIN_W-1]};
            ovf_d   = ovf_q | adj[DW-1];
            sh_d    = sh_q << 1;
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CW'(BIN_W - 1) ? ST_COMMIT : ST_CONVERT;
        end else if (state_q == ST_COMMIT) begin
            state_d    = ST_IDLE;
            nib_d      = commit_nib;
            dash_d     = mode_q & ovf_q;
            overflow_d = mode_q & ovf_q;
            bdp_d      = mode_q & ovf_q ? '0 : pdp_q;
            blank_d    = commit_blank;
        end
        in_ready_d = state_d == ST_IDLE;
    end

    always_comb begin
        tc        = rcnt_q == RW'(REFRESH_DIV - 1);
        rcnt_d    = tc ? '0 : rcnt_q + 1'b1;
        idx_d     = tc ? (idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
        cur_d     = tc ? idx_q : cur_q;
        on_d      = on_q | tc;
        anode_d   = tc ? ~(NUM_DIGITS'(1) << idx_q) : anode_q;
        cathode_d = on_d ? glyph : 8'hFF;
    end

    mod_seg_glyph u_glyph (
        .nibble  (nib_q[4*cur_d +: 4]),
        .blank   (blank_q[cur_d]),
        .dash    (dash_q),
        .dp      (bdp_q[cur_d]),
        .cathode (glyph)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            sh_q       <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            pdp_q      <= '0;
            blz_q      <= 1'b0;
            nib_q      <= '0;
            bdp_q      <= '0;
            blank_q    <= '0;
            dash_q     <= 1'b1;
            overflow_q <= 1'b0;
            rcnt_q     <= '0;
            idx_q      <= '0;
            cur_q      <= '0;
            on_q       <= 1'b0;
            anode_q    <= '1;
            cathode_q  <= 8'hFF;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            sh_q       <= sh_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            pdp_q      <= pdp_d;
            blz_q      <= blz_d;
            nib_q      <= nib_d;
            bdp_q      <= bdp_d;
            blank_q    <= blank_d;
            dash_q     <= dash_d;
            overflow_q <= overflow_d;
            rcnt_q     <= rcnt_d;
            idx_q      <= idx_d;
            cur_q      <= cur_d;
            on_q       <= on_d;
            anode_q    <= anode_d;
            cathode_q  <= cathode_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign rg_anode   = anode_q;
    assign rg_cathode = cathode_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_mod_seven_segment_scanner.sv
// tb_mod_seven_segment_scanner: directed scoreboard bench for the seven-segment scanner
module tb_mod_seven_segment_scanner;
    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [7:0] ca;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] in_value = '0;
    logic        in_mode = 1'b0;
    logic [3:0]  in_dp = '0;
    logic        in_blank_lz = 1'b0;
    logic [3:0]  rg_anode;
    logic [7:0]  rg_cathode;
    logic        overflow;
    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mod_seven_segment_scanner #(.NUM_DIGITS(4), .BIN_W(14), .REFRESH_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .in_mode     (in_mode),
        .in_dp       (in_dp),
        .in_blank_lz (in_blank_lz),
        .rg_anode    (rg_anode),
        .rg_cathode  (rg_cathode),
        .overflow    (overflow)
    );

    function automatic logic [6:0] g7(input int d);
        case (d)
            0: return 7'b0000001;   1: return 7'b1001111;   2: return 7'b0010010;   3: return 7'b0000110;
            4: return 7'b1001100;   5: return 7'b0100100;   6: return 7'b0100000;   7: return 7'b0001111;
            8: return 7'b0000000;   9: return 7'b0001100;   10: return 7'b0001000;  11: return 7'b1100000;
            12: return 7'b0110001;  13: return 7'b1000010;  14: return 7'b0110000;  15: return 7'b0111000;
            16: return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int v, input bit m, input logic [3:0] dp,
                              input bit blz, output bit ovf);
        int   d[4];
        int   msd;
        exp_t it;
        ovf = m && v >= 10000;
        msd = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = m ? (v / (10 ** i)) % 10 : (v >> (4 * i)) & 15;
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < 4; i++) begin
            it.tag = $sformatf("%s_d%0d", tag, i);
            it.an  = ~(4'b0001 << i);
            it.ca  = ovf ? {g7(16), 1'b1} : (blz && i > msd) ? {g7(17), ~dp[i]} : {g7(d[i]), ~dp[i]};
            sb.push_back(it);
        end
    endtask

    task automatic drain();
        exp_t it;
        int   n;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (rg_anode !== it.an && n < 64);
            chk({it.tag, "_anode"}, 32'(rg_anode), 32'(it.an));
            chk(it.tag, 32'(rg_cathode), 32'(it.ca));
        end
    endtask

    task automatic accept(input int v, input bit m, input logic [3:0] dp, input bit blz, input string tag);
        int n;
        @(negedge clk);
        in_value = 14'(v);
        in_mode = m;
        in_dp = dp;
        in_blank_lz = blz;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run(input string tag, input int v, input bit m, input logic [3:0] dp,
                       input bit blz, input int busy);
        bit ovf;
        int n;
        expect_val(tag, v, m, dp, blz, ovf);
        accept(v, m, dp, blz, tag);
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready || n > 64) break;
            n++;
        end
        chk({tag, "_busy"}, 32'(n), 32'(busy));
        @(negedge clk);
        chk({tag, "_ovf"}, 32'(overflow), 32'(ovf));
        drain();
    endtask

    initial begin
        exp_t        it;
        logic [3:0]  ea;
        repeat (3) @(negedge clk);
        chk("rst_anode", 32'(rg_anode), 32'hF);
        chk("rst_cathode", 32'(rg_cathode), 32'hFF);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) chk("ready_after_rst", 32'(in_ready), 32'd1);
            ea = k < 4 ? 4'hF : ~(4'b0001 << (((k - 4) / 4) % 4));
            chk($sformatf("scan_anode_%0d", k), 32'(rg_anode), 32'(ea));
            chk($sformatf("scan_cathode_%0d", k), 32'(rg_cathode), k < 4 ? 32'hFF : 32'hFD);
        end
        run("hex1A3F", 'h1A3F, 1'b0, 4'b0001, 1'b0, 1);
        run("dec9876", 9876, 1'b1, 4'b0000, 1'b0, 15);
        run("dec42", 42, 1'b1, 4'b0000, 1'b1, 15);
        run("dec0", 0, 1'b1, 4'b0000, 1'b1, 15);
        run("dec16383", 16383, 1'b1, 4'b0010, 1'b0, 15);
        run("dec12000", 12000, 1'b1, 4'b1111, 1'b0, 15);
        run("hex0005", 'h0005, 1'b0, 4'b0000, 1'b0, 1);
        accept(1234, 1'b1, 4'b0000, 1'b0, "abort");
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_anode", 32'(rg_anode), 32'hF);
        chk("abort_cathode", 32'(rg_cathode), 32'hFF);
        chk("abort_ready", 32'(in_ready), 32'd0);
        chk("abort_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int r = 0; r < 8; r++) begin
            it.tag = $sformatf("abort_dash%0d", r);
            it.an  = ~(4'b0001 << (r % 4));
            it.ca  = 8'hFD;
            sb.push_back(it);
        end
        drain();
        chk("abort_ovf_after", 32'(overflow), 32'd0);
        run("post_abort", 'h00C7, 1'b0, 4'b0100, 1'b1, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
